// File: rtl/stream_mux_rr_if.sv
// rtl/stream_mux_rr_if.sv - handshake bundle between producers, the stream mux and its consumer
interface stream_mux_rr_if #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) ();
  logic                 mode;
  logic [SELW-1:0]      sel;
  logic [NCH-1:0]       in_valid;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_ready;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_ch;
  logic                 out_ready;

  // slave is the mux side, master is the producer/consumer environment
  modport slave (
    input  mode, sel, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );

  modport master (
    output mode, sel, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - N-channel stream mux, manual or round-robin grant, registered output
module stream_mux_rr #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic           clk,
  input  logic           rst,
  stream_mux_rr_if.slave bus
);

  logic [SELW-1:0] ptr;
  logic            can_load;
  logic            gnt_vld;
  logic [SELW-1:0] gnt_idx;
  int              idx;

  assign can_load = !bus.out_valid || bus.out_ready;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    if (!bus.mode) begin
      // sel values at or beyond NCH simply never match a channel
      for (int k = 0; k < NCH; k++) begin
        if (int'(bus.sel) == k && bus.in_valid[k]) begin
          gnt_vld = 1'b1;
          gnt_idx = SELW'(k);
        end
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        idx = (int'(ptr) + i) % NCH;
        if (!gnt_vld && bus.in_valid[idx]) begin
          gnt_vld = 1'b1;
          gnt_idx = SELW'(idx);
        end
      end
    end
  end

  always_comb begin
    bus.in_ready = '0;
    if (!rst && can_load && gnt_vld)
      bus.in_ready[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_ch    <= '0;
      ptr           <= '0;
    end else if (can_load && gnt_vld) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= bus.in_data[int'(gnt_idx)*WIDTH +: WIDTH];
      bus.out_ch    <= gnt_idx;
      if (bus.mode)
        ptr <= (gnt_idx == SELW'(NCH-1)) ? '0 : gnt_idx + 1'b1;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb/tb_stream_mux_rr.sv - self-checking bench for stream_mux_rr
module tb_stream_mux_rr;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  stream_mux_rr_if #(.WIDTH(8), .NCH(4), .SELW(2)) bus ();
  stream_mux_rr_if #(.WIDTH(8), .NCH(3), .SELW(2)) bus3 ();

  stream_mux_rr #(.WIDTH(8), .NCH(4), .SELW(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  stream_mux_rr #(.WIDTH(8), .NCH(3), .SELW(2)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the held beat plus the round-robin start position
  int         m_ptr;
  logic       m_valid;
  logic [7:0] m_data;
  int         m_ch;
  int         mg;

  function automatic int exp_grant();
    int ch;
    if (m_valid && !bus.out_ready) return -1;
    if (!bus.mode) begin
      if (int'(bus.sel) < 4 && bus.in_valid[bus.sel]) return int'(bus.sel);
      return -1;
    end
    for (int off = 0; off < 4; off++) begin
      ch = (m_ptr + off) % 4;
      if (bus.in_valid[ch]) return ch;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ptr = 0; m_valid = 0; m_data = 0; m_ch = 0;
    end else begin
      mg = exp_grant();
      if (mg >= 0) begin
        m_valid = 1;
        m_data  = bus.in_data[mg*8 +: 8];
        m_ch    = mg;
        if (bus.mode) m_ptr = (mg + 1) % 4;
      end else if (bus.out_ready) begin
        m_valid = 0;
      end
    end
  end

  always @(negedge clk) begin
    int g;
    if (!rst) begin
      g = exp_grant();
      check("mdl_out_valid", 32'(bus.out_valid), 32'(m_valid));
      check("mdl_out_data", 32'(bus.out_data), 32'(m_data));
      check("mdl_out_ch", 32'(bus.out_ch), 32'(m_ch));
      check("mdl_in_ready", 32'(bus.in_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int         seq_exp [6] = '{0, 1, 2, 3, 0, 1};
  logic [7:0] held_data;
  logic [1:0] held_ch;

  initial begin
    bus.mode = 0; bus.sel = 0; bus.in_valid = 0; bus.out_ready = 0;
    bus.in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    bus3.mode = 0; bus3.sel = 0; bus3.in_valid = 0; bus3.out_ready = 1;
    bus3.in_data = {8'hB2, 8'hB1, 8'hB0};
    step(); step();
    rst = 0;
    step();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_out_ch", 32'(bus.out_ch), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);

    // manual select of channel 2
    bus.mode = 0; bus.sel = 2; bus.in_valid = 4'b1111; bus.out_ready = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("man_out_data", 32'(bus.out_data), 32'hA2);
      check("man_out_ch", 32'(bus.out_ch), 32'd2);
      check("man_in_ready", 32'(bus.in_ready), 32'b0100);
    end

    // reset mid-traffic in round-robin mode
    bus.mode = 1;
    step(); step();
    #2 rst = 1;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_out_ch", 32'(bus.out_ch), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    step();
    rst = 0;

    // round-robin from ptr=0, all channels valid
    for (int i = 0; i < 6; i++) begin
      step();
      check("rr_out_valid", 32'(bus.out_valid), 32'd1);
      check("rr_seq_ch", 32'(bus.out_ch), 32'(seq_exp[i]));
    end

    // grant 2 alone leaves ptr at 3, then only channels 0/1 valid
    bus.in_valid = 4'b0100;
    step();
    check("wrap_pre_ch", 32'(bus.out_ch), 32'd2);
    bus.in_valid = 4'b0011;
    step();
    check("wrap_ch0", 32'(bus.out_ch), 32'd0);
    step();
    check("wrap_ch1", 32'(bus.out_ch), 32'd1);
    step();
    check("wrap_ch0b", 32'(bus.out_ch), 32'd0);
    check("wrap_data", 32'(bus.out_data), 32'hA0);

    // backpressure: held beat stays put, no input accepted
    bus.out_ready = 0;
    held_data = bus.out_data;
    held_ch   = bus.out_ch;
    #1;
    check("bp_in_ready0", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_out_data", 32'(bus.out_data), 32'(held_data));
      check("bp_out_ch", 32'(bus.out_ch), 32'(held_ch));
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1;
    step();
    check("bp_rel_ch", 32'(bus.out_ch), 32'd1);
    check("bp_rel_data", 32'(bus.out_data), 32'hA1);

    // manual select of an invalid channel drains the output
    bus.mode = 0; bus.sel = 1; bus.in_valid = 4'b1101;
    #1;
    check("inv_in_ready", 32'(bus.in_ready), 32'd0);
    step();
    check("inv_out_valid", 32'(bus.out_valid), 32'd0);
    step();
    check("inv_out_valid2", 32'(bus.out_valid), 32'd0);

    // three-channel instance: sel beyond the channel count never grants
    bus3.sel = 3; bus3.in_valid = 3'b111;
    #1;
    check("n3_in_ready", 32'(bus3.in_ready), 32'd0);
    step();
    check("n3_out_valid", 32'(bus3.out_valid), 32'd0);
    bus3.sel = 2;
    #1;
    check("n3_sel2_ready", 32'(bus3.in_ready), 32'b100);
    step();
    check("n3_sel2_data", 32'(bus3.out_data), 32'hB2);
    check("n3_sel2_ch", 32'(bus3.out_ch), 32'd2);

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
